exec_muldiv_unit: RTL

- Execute-stage arithmetic core sitting directly upstream of the memory stage; its result becomes the alu_result field of the ex/mem register.
- Single-cycle ALU ops resolve combinationally.
- RV64M multiply/divide ops (incl. W variants) run on an iterative shift-add / restoring-divide datapath, holding ok low until the result is ready.
- Pipeline advance is gated on ok, matching the stage-wide unified-ok scheme.

---
 rtl/exec_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_muldiv_unit.sv
// Execute-stage arithmetic core: single-cycle ALU plus an iterative RV64M
// multiply (shift-add) / divide (restoring) engine with tag-based completion.
module exec_muldiv_unit #(
  parameter int XLEN = 64,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] inst_counter,
  output logic [XLEN-1:0] result,
  output logic            ok,
  output logic            busy
);
  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] F_ADD  = 5'd0;
  localparam logic [4:0] F_SUB  = 5'd1;
  localparam logic [4:0] F_AND  = 5'd2;
  localparam logic [4:0] F_OR   = 5'd3;
  localparam logic [4:0] F_XOR  = 5'd4;
  localparam logic [4:0] F_SLL  = 5'd5;
  localparam logic [4:0] F_SRL  = 5'd6;
  localparam logic [4:0] F_SRA  = 5'd7;
  localparam logic [4:0] F_SLT  = 5'd8;
  localparam logic [4:0] F_SLTU = 5'd9;
  localparam logic [4:0] F_MUL  = 5'd16;
  localparam logic [4:0] F_DIV  = 5'd17;
  localparam logic [4:0] F_DIVU = 5'd18;
  localparam logic [4:0] F_REM  = 5'd19;
  localparam logic [4:0] F_REMU = 5'd20;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic                   is_w;
  logic [4:0]             fn;
  logic signed [XLEN-1:0] s1_s, s2_s, sra_full;
  logic signed [HALF-1:0] s1w_s, sra_half;
  logic [XLEN-1:0]        alu_res;

  assign is_w     = op[OP_W-1];
  assign fn       = op[4:0];
  assign s1_s     = src1;
  assign s2_s     = src2;
  assign s1w_s    = src1[HALF-1:0];
  assign sra_full = s1_s >>> src2[CNT_W-1:0];
  assign sra_half = s1w_s >>> src2[CNT_W-2:0];

  always_comb begin
    alu_res = '0;
    case (fn)
      F_ADD:  alu_res = is_w ? sext_half(src1[HALF-1:0] + src2[HALF-1:0]) : src1 + src2;
      F_SUB:  alu_res = is_w ? sext_half(src1[HALF-1:0] - src2[HALF-1:0]) : src1 - src2;
      F_AND:  alu_res = src1 & src2;
      F_OR:   alu_res = src1 | src2;
      F_XOR:  alu_res = src1 ^ src2;
      F_SLL:  alu_res = is_w ? sext_half(src1[HALF-1:0] << src2[CNT_W-2:0])
                             : src1 << src2[CNT_W-1:0];
      F_SRL:  alu_res = is_w ? sext_half(src1[HALF-1:0] >> src2[CNT_W-2:0])
                             : src1 >> src2[CNT_W-1:0];
      F_SRA:  alu_res = is_w ? sext_half(sra_half) : sra_full;
      F_SLT:  alu_res = {{(XLEN-1){1'b0}}, s1_s < s2_s};
      F_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      default: alu_res = '0;
    endcase
  end

  // Operand preparation for the iterative engine
  logic            is_md, is_mul, sgn, want_rem;
  logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, special_res;
  logic            a_neg, b_neg, div_zero, div_ovf;

  assign is_md    = fn inside {[F_MUL:F_REMU]};
  assign is_mul   = (fn == F_MUL);
  assign sgn      = (fn == F_DIV) || (fn == F_REM);
  assign want_rem = (fn == F_REM) || (fn == F_REMU);

  assign op_a  = is_w ? (sgn ? sext_half(src1[HALF-1:0]) : {{HALF{1'b0}}, src1[HALF-1:0]}) : src1;
  assign op_b  = is_w ? (sgn ? sext_half(src2[HALF-1:0]) : {{HALF{1'b0}}, src2[HALF-1:0]}) : src2;
  assign a_neg = sgn & op_a[XLEN-1];
  assign b_neg = sgn & op_b[XLEN-1];
  assign abs_a = a_neg ? negate(op_a) : op_a;
  assign abs_b = b_neg ? negate(op_b) : op_b;

  assign div_zero = is_w ? (src2[HALF-1:0] == '0) : (src2 == '0);
  assign div_ovf  = sgn & (is_w ? (src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}} && src2[HALF-1:0] == '1)
                                : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
  assign special_res = div_zero ? (want_rem ? (is_w ? sext_half(src1[HALF-1:0]) : src1) : '1)
                                : (want_rem ? '0 : (is_w ? sext_half(src1[HALF-1:0]) : src1));

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  tag_q, tag_d, last_tag_q, last_tag_d, result_q, result_d;
  logic [XLEN-1:0]  acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic             w_q, w_d, want_rem_q, want_rem_d, neg_res_q, neg_res_d;
  logic             start;

  assign start = (state_q == S_IDLE) & in_valid & is_md & ~flush & ~rst & (inst_counter != last_tag_q);

  // One iteration step: acc/opa/opb hold product/multiplicand/multiplier for
  // MUL and remainder/dividend-quotient shift register/divisor for DIV.
  logic [XLEN-1:0] mul_acc, mul_final, div_rem, div_quo, div_raw, div_fix, div_final;
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit;

  assign mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
  assign mul_final = w_q ? sext_half(mul_acc[HALF-1:0]) : mul_acc;
  assign rem_sh    = {acc_q, opa_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, opb_q};
  assign q_bit     = ~diff[XLEN];
  assign div_rem   = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_quo   = {opa_q[XLEN-2:0], q_bit};
  assign div_raw   = want_rem_q ? div_rem : div_quo;
  assign div_fix   = neg_res_q ? negate(div_raw) : div_raw;
  assign div_final = w_q ? sext_half(div_fix[HALF-1:0]) : div_fix;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    last_tag_d = last_tag_q;
    result_d   = result_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    w_d        = w_q;
    want_rem_d = want_rem_q;
    neg_res_d  = neg_res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tag_d      = inst_counter;
          w_d        = is_w;
          want_rem_d = want_rem;
          neg_res_d  = want_rem ? a_neg : (a_neg ^ b_neg);
          cnt_d      = is_w ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
          acc_d      = '0;
          if (is_mul) begin
            state_d = S_MUL;
            opa_d   = op_a;
            opb_d   = op_b;
          end else if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d = S_DIV;
            opa_d   = is_w ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
            opb_d   = abs_b;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mul_final;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        acc_d = div_rem;
        opa_d = div_quo;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = div_final;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        // A retired op records its tag so a stalled instruction cannot re-issue
        if (tag_q != inst_counter) begin
          state_d = S_IDLE;
        end else if (enable) begin
          state_d    = S_IDLE;
          last_tag_d = tag_q;
        end
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      last_tag_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      last_tag_q <= last_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q      <= tag_d;
    acc_q      <= acc_d;
    opa_q      <= opa_d;
    opb_q      <= opb_d;
    w_q        <= w_d;
    want_rem_q <= want_rem_d;
    neg_res_q  <= neg_res_d;
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);

  always_comb begin
    result = '0;
    ok     = 1'b0;
    if (state_q == S_DONE) begin
      result = result_q;
      ok     = (tag_q == inst_counter);
    end else if (state_q == S_IDLE && in_valid && !is_md) begin
      result = alu_res;
      ok     = 1'b1;
    end
    if (flush || rst) ok = 1'b0;
  end

endmodule
